inventory_tracker: RTL and testbench
====================================

# inventory_tracker

Upstream neighbour of the order-quantity stage in the market-making pipeline. It accumulates bid-side and ask-side fill executions into a signed net position, optionally clamps that position at a configured limit with hysteresis flags, and normalises it to a signed fixed-point inventory state. The `inventory_state` output drives the order-quantity stage directly.

## Interface

Clock `i_clk`; reset `i_rst`, asynchronous, active-high.

Parameters:
- `QTY_W`, default 32: fill quantity width (unsigned).
- `POS_W`, default 48: signed position accumulator width.
- `FRAC_BITS`, default 34: fractional bits of `inventory_state`.
- `MAX_POS`, default 1000: position limit, in contracts.
- `LIMIT_HYST`, default 50: contracts below the limit required to release a limit flag.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: async active-high reset.
- `i_bid_fill_valid` in 1: bid quote filled this cycle (we bought).
- `i_bid_fill_qty` in QTY_W: bought quantity.
- `i_ask_fill_valid` in 1: ask quote filled this cycle (we sold).
- `i_ask_fill_qty` in QTY_W: sold quantity.
- `i_clear` in 1: synchronous position clear (end-of-session / reconcile).
- `o_position` out POS_W: signed net position.
- `inventory_state` out 64: signed, position × 2^FRAC_BITS / MAX_POS.
- `o_inv_valid` out 1: one-cycle pulse when `inventory_state` updates.
- `o_long_limit` out 1: long limit reached; downstream suppresses bids.
- `o_short_limit` out 1: short limit reached; downstream suppresses asks.

## Operation

- Stage 0 (delta register):
  - delta = (bid_valid ? bid_qty : 0) − (ask_valid ? ask_qty : 0), signed QTY_W+1.
  - d_valid = bid_valid | ask_valid.
  - Simultaneous bid and ask fills net in one cycle.
  - Zero-quantity fills still set d_valid.
- Stage 1 (accumulate): when d_valid, position ← position + delta.
  - With `INV_LIMIT_EN`: result clamped to [−MAX_POS, +MAX_POS].
  - Without: accumulator saturates only at the POS_W signed range.
- Stage 2 (normalise): product = position × RECIP, where RECIP = floor(2^FRAC_BITS / MAX_POS) is a package constant.
  - Product is saturated to the 64-bit signed range and registered to `inventory_state`.
  - `o_inv_valid` pulses alongside.
- `i_clear`:
  - Same edge: position ← 0, stage-0 d_valid ← 0 (that cycle's fills are discarded), limit FSM ← NORMAL.
  - Next edge: `inventory_state` ← 0 and `o_inv_valid` pulses.
  - Clear has priority over a same-cycle fill.
- Limit FSM (`INV_LIMIT_EN` only), evaluated on the updated position:
  - NORMAL → LONG_LIMIT when position ≥ MAX_POS.
  - NORMAL → SHORT_LIMIT when position ≤ −MAX_POS.
  - LONG_LIMIT → NORMAL when position ≤ MAX_POS − LIMIT_HYST.
  - SHORT_LIMIT → NORMAL when position ≥ −(MAX_POS − LIMIT_HYST).
  - LONG_LIMIT ↔ SHORT_LIMIT directly is impossible once clamped.
  - `o_long_limit` = (state == LONG_LIMIT); `o_short_limit` = (state == SHORT_LIMIT); both registered.

## Timing

- Reset values: all outputs and registers 0; FSM NORMAL. Reset takes effect immediately and discards in-flight fills.
- Fill sampled at edge N → delta at N; `o_position` and limit flags valid after edge N+1; `inventory_state` and `o_inv_valid` after edge N+2. Total latency 3 edges from sample to normalised output.
- Fully pipelined: one fill pair accepted every cycle, no backpressure.
- Consecutive fills accumulate back-to-back with no bubbles.

## Configuration

Macro `INV_LIMIT_EN`:
- Defined: position clamp at ±MAX_POS, limit FSM, and hysteresis flags are built. `inventory_state` stays within ±2^FRAC_BITS (about ±1.0).
- Undefined: no clamp and no FSM. `o_long_limit` and `o_short_limit` are tied 0. Position range is bounded only by POS_W saturation, and `inventory_state` by 64-bit saturation.

## Structure

- Shared package `hft_pkg` holds:
  - the RECIP constant function/localparam;
  - the limit-state enum `inv_limit_e` {NORMAL, LONG_LIMIT, SHORT_LIMIT};
  - the signed saturation helper function.
- One sub-module, `inv_normaliser`: the stage-2 multiply/saturate register. It is reusable by other fixed-point scaling stages.

## Test plan

Defaults (MAX_POS=1000, FRAC_BITS=34) apply unless stated; RECIP = 17179869.

1. Reset, then bid fill 500 → `o_position`=500 after 2 edges; `inventory_state`=8589934500 with `o_inv_valid` pulse after 3 edges.
2. Same-cycle bid 300 and ask 120 → single update, `o_position`=180, `inventory_state`=3092376420.
3. `INV_LIMIT_EN`: bids 600 then 700 → `o_position`=1000, `o_long_limit`=1, `inventory_state`=17179869000. Ask 40 → position 960, flag stays 1. Ask 20 → position 940, flag clears.
4. Ask fills totalling 1200 from 0 → `o_position`=−1000, `o_short_limit`=1, `inventory_state`=−17179869000.
5. `i_clear` asserted in the same cycle as bid 50 at position 400 → `o_position`=0, fill discarded, flags 0, next `inventory_state`=0 with `o_inv_valid` pulse.
6. `i_rst` asserted mid-stream with fills in stages 0–1 → all outputs 0 immediately; first fill after release produces a correct 3-edge result.

Source files
------------

// File: rtl/hft_pkg.sv
// hft_pkg: shared types and helpers for the market-making pipeline.
//   inv_limit_e : inventory limit FSM states.
//   inv_recip() : floor(2^frac_bits / max_pos), the normalising multiplier.
//   sat_s()     : clamp a signed 128-bit value into a w-bit signed range.
package hft_pkg;

    typedef enum logic [1:0] {
        NORMAL      = 2'd0,
        LONG_LIMIT  = 2'd1,
        SHORT_LIMIT = 2'd2
    } inv_limit_e;

    // Fixed-point reciprocal, so normalisation is a multiply instead of a divide.
    function automatic logic [63:0] inv_recip(input int frac_bits, input int max_pos);
        return (64'd1 << frac_bits) / 64'(max_pos);
    endfunction

    // Callers cast the result down to w bits; the 128-bit carrier keeps the
    // helper usable for any width up to 128.
    function automatic logic signed [127:0] sat_s(input logic signed [127:0] x, input int w);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/inv_normaliser.sv
// inv_normaliser: registered signed multiply by an unsigned constant, with
// saturation to OUT_W signed bits. Updates only when i_valid is high.
//   i_clk, i_rst : clock, async active-high reset
//   i_valid      : load a new product this edge
//   i_value      : signed operand (IN_W)
//   o_value      : saturated product (OUT_W), held between updates
//   o_valid      : one-cycle pulse when o_value updated
import hft_pkg::*;

module inv_normaliser #(
    parameter int          IN_W   = 48,
    parameter int          OUT_W  = 64,
    parameter int          COEF_W = 64,
    parameter logic [COEF_W-1:0] COEF = '1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    input  logic signed [IN_W-1:0]  i_value,
    output logic signed [OUT_W-1:0] o_value,
    output logic                    o_valid
);
    // Coefficient is zero-extended by one bit so it multiplies as positive.
    localparam int PROD_W = IN_W + COEF_W + 1;

    logic signed [PROD_W-1:0] prod_w;
    logic signed [OUT_W-1:0]  sat_w;
    logic signed [OUT_W-1:0]  value_q;
    logic                     valid_q;

    assign prod_w = PROD_W'(i_value) * PROD_W'($signed({1'b0, COEF}));
    assign sat_w  = OUT_W'(sat_s(128'(prod_w), OUT_W));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= i_valid;
            if (i_valid) value_q <= sat_w;
        end
    end

    assign o_value = value_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/inventory_tracker.sv
// inventory_tracker: nets bid/ask fills into a signed position and publishes
// it as a fixed-point inventory state (position * 2^FRAC_BITS / MAX_POS).
// Build option: define INV_LIMIT_EN to clamp the position at +/-MAX_POS and
// build the hysteretic long/short limit flags; otherwise the flags are 0 and
// the position saturates only at the POS_W signed range.
//   i_clk, i_rst                  : clock, async active-high reset
//   i_bid_fill_valid/_qty         : we bought qty this cycle
//   i_ask_fill_valid/_qty         : we sold qty this cycle
//   i_clear                       : synchronous position clear
//   o_position                    : signed net position (2 edges after fill)
//   inventory_state, o_inv_valid  : normalised position + update pulse (3 edges)
//   o_long_limit, o_short_limit   : limit flags (registered)
import hft_pkg::*;

module inventory_tracker #(
    parameter int QTY_W      = 32,
    parameter int POS_W      = 48,
    parameter int FRAC_BITS  = 34,
    parameter int MAX_POS    = 1000,
    parameter int LIMIT_HYST = 50
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_bid_fill_valid,
    input  logic [QTY_W-1:0]        i_bid_fill_qty,
    input  logic                    i_ask_fill_valid,
    input  logic [QTY_W-1:0]        i_ask_fill_qty,
    input  logic                    i_clear,
    output logic signed [POS_W-1:0] o_position,
    output logic signed [63:0]      inventory_state,
    output logic                    o_inv_valid,
    output logic                    o_long_limit,
    output logic                    o_short_limit
);
    localparam logic [63:0] RECIP = inv_recip(FRAC_BITS, MAX_POS);

    if (LIMIT_HYST < 0 || LIMIT_HYST >= MAX_POS || QTY_W >= POS_W ||
        POS_W + 65 > 128 || FRAC_BITS > 62) begin : g_bad_cfg
        $error("inventory_tracker: unsupported parameter set");
    end

    // ---- stage 0: net the two sides into one signed delta
    logic [QTY_W:0]          bid_ext, ask_ext;
    logic signed [QTY_W:0]   delta_q;
    logic                    dvld_q;

    assign bid_ext = i_bid_fill_valid ? {1'b0, i_bid_fill_qty} : '0;
    assign ask_ext = i_ask_fill_valid ? {1'b0, i_ask_fill_qty} : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            delta_q <= '0;
            dvld_q  <= 1'b0;
        end else begin
            delta_q <= $signed(bid_ext - ask_ext);
            dvld_q  <= ~i_clear & (i_bid_fill_valid | i_ask_fill_valid);
        end
    end

    // ---- stage 1: accumulate
    logic signed [POS_W:0]   sum_w;
    logic signed [POS_W-1:0] pos_upd, pos_d, position_q;
    logic                    pvld_q;

    assign sum_w = (POS_W+1)'(position_q) + (POS_W+1)'(delta_q);

`ifdef INV_LIMIT_EN
    localparam logic signed [POS_W:0]   CLAMP_HI = (POS_W+1)'(MAX_POS);
    localparam logic signed [POS_W:0]   CLAMP_LO = -CLAMP_HI;
    localparam logic signed [POS_W-1:0] LIM_HI   = POS_W'(MAX_POS);
    localparam logic signed [POS_W-1:0] LIM_LO   = -LIM_HI;
    localparam logic signed [POS_W-1:0] REL_HI   = POS_W'(MAX_POS - LIMIT_HYST);
    localparam logic signed [POS_W-1:0] REL_LO   = -REL_HI;

    assign pos_upd = POS_W'((sum_w > CLAMP_HI) ? CLAMP_HI :
                            (sum_w < CLAMP_LO) ? CLAMP_LO : sum_w);
`else
    assign pos_upd = POS_W'(sat_s(128'(sum_w), POS_W));
`endif

    // Clear wins over any delta already in flight.
    assign pos_d = i_clear ? '0 : (dvld_q ? pos_upd : position_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            position_q <= '0;
            pvld_q     <= 1'b0;
        end else begin
            position_q <= pos_d;
            pvld_q     <= i_clear | dvld_q;  // clear also republishes a zero state
        end
    end

    assign o_position = position_q;

`ifdef INV_LIMIT_EN
    // ---- limit FSM, evaluated on the position being written this edge
    inv_limit_e state_q;
    logic       long_q, short_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || i_clear) begin
            state_q <= NORMAL;
            long_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (pos_d >= LIM_HI) begin
                        state_q <= LONG_LIMIT;
                        long_q  <= 1'b1;
                    end else if (pos_d <= LIM_LO) begin
                        state_q <= SHORT_LIMIT;
                        short_q <= 1'b1;
                    end
                end
                LONG_LIMIT: begin
                    if (pos_d <= REL_HI) begin
                        state_q <= NORMAL;
                        long_q  <= 1'b0;
                    end
                end
                SHORT_LIMIT: begin
                    if (pos_d >= REL_LO) begin
                        state_q <= NORMAL;
                        short_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= NORMAL;
                    long_q  <= 1'b0;
                    short_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_long_limit  = long_q;
    assign o_short_limit = short_q;
`else
    assign o_long_limit  = 1'b0;
    assign o_short_limit = 1'b0;
`endif

    // ---- stage 2: normalise
    inv_normaliser #(
        .IN_W   (POS_W),
        .OUT_W  (64),
        .COEF_W (64),
        .COEF   (RECIP)
    ) u_norm (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (pvld_q),
        .i_value (position_q),
        .o_value (inventory_state),
        .o_valid (o_inv_valid)
    );

endmodule

// File: tb/tb_inventory_tracker.sv
// Directed bench for inventory_tracker at default parameters
// (RECIP = 17179869). Expectations switch on INV_LIMIT_EN.
module tb_inventory_tracker;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               bid_v = 1'b0, ask_v = 1'b0, clr = 1'b0;
    logic [31:0]        bid_q = '0, ask_q = '0;
    logic signed [47:0] pos;
    logic signed [63:0] inv;
    logic               inv_v, long_f, short_f;

    int chk  = 0;
    int pass = 0;

    always #5 clk = ~clk;

    inventory_tracker dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_bid_fill_valid (bid_v),
        .i_bid_fill_qty   (bid_q),
        .i_ask_fill_valid (ask_v),
        .i_ask_fill_qty   (ask_q),
        .i_clear          (clr),
        .o_position       (pos),
        .inventory_state  (inv),
        .o_inv_valid      (inv_v),
        .o_long_limit     (long_f),
        .o_short_limit    (short_f)
    );

    // Present one cycle of inputs, step past the edge, return inputs to idle.
    task automatic drive(input logic bv, input logic [31:0] bq,
                         input logic av, input logic [31:0] aq, input logic c);
        bid_v = bv; bid_q = bq; ask_v = av; ask_q = aq; clr = c;
        @(posedge clk); #1;
        bid_v = 1'b0; bid_q = '0; ask_v = 1'b0; ask_q = '0; clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_clear();
        drive(1'b0, 0, 1'b0, 0, 1'b1);
        idle(2);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #3;
        chk++; if (pos !== 0)     $display("FAIL rst_pos: got %0d exp 0", pos); else pass++;
        chk++; if (inv !== 0)     $display("FAIL rst_inv: got %0d exp 0", inv); else pass++;
        chk++; if (inv_v !== 0)   $display("FAIL rst_valid: got %b exp 0", inv_v); else pass++;
        chk++; if (long_f !== 0)  $display("FAIL rst_long: got %b exp 0", long_f); else pass++;
        chk++; if (short_f !== 0) $display("FAIL rst_short: got %b exp 0", short_f); else pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_single_bid();
        drive(1'b1, 500, 1'b0, 0, 1'b0);
        chk++; if (pos !== 0) $display("FAIL bid_pos_early: got %0d exp 0", pos); else pass++;
        idle(1);
        chk++; if (pos !== 500) $display("FAIL bid_pos: got %0d exp 500", pos); else pass++;
        chk++; if (inv_v !== 0) $display("FAIL bid_valid_early: got %b exp 0", inv_v); else pass++;
        idle(1);
        chk++; if (inv !== 64'sd8589934500) $display("FAIL bid_inv: got %0d exp 8589934500", inv); else pass++;
        chk++; if (inv_v !== 1) $display("FAIL bid_valid: got %b exp 1", inv_v); else pass++;
        idle(1);
        chk++; if (inv_v !== 0) $display("FAIL bid_valid_pulse: got %b exp 0", inv_v); else pass++;
    endtask

    task automatic test_netting();
        do_clear();
        drive(1'b1, 300, 1'b1, 120, 1'b0);
        idle(1);
        chk++; if (pos !== 180) $display("FAIL net_pos: got %0d exp 180", pos); else pass++;
        idle(1);
        chk++; if (inv !== 64'sd3092376420) $display("FAIL net_inv: got %0d exp 3092376420", inv); else pass++;
        chk++; if (inv_v !== 1) $display("FAIL net_valid: got %b exp 1", inv_v); else pass++;
        idle(1);
        chk++; if (inv_v !== 0) $display("FAIL net_single: got %b exp 0", inv_v); else pass++;
    endtask

    task automatic test_long_limit();
        longint     e_pos0, e_pos1, e_pos2;
        logic signed [63:0] e_inv;
        logic       e_l0, e_l1;
`ifdef INV_LIMIT_EN
        e_pos0 = 1000; e_inv = 64'sd17179869000; e_l0 = 1'b1;
        e_pos1 = 960;  e_l1 = 1'b1; e_pos2 = 940;
`else
        e_pos0 = 1300; e_inv = 64'sd22333829700; e_l0 = 1'b0;
        e_pos1 = 1260; e_l1 = 1'b0; e_pos2 = 1240;
`endif
        do_clear();
        drive(1'b1, 600, 1'b0, 0, 1'b0);
        drive(1'b1, 700, 1'b0, 0, 1'b0);
        idle(1);
        chk++; if (pos !== 48'(e_pos0)) $display("FAIL long_pos: got %0d exp %0d", pos, e_pos0); else pass++;
        chk++; if (long_f !== e_l0) $display("FAIL long_flag: got %b exp %b", long_f, e_l0); else pass++;
        idle(1);
        chk++; if (inv !== e_inv) $display("FAIL long_inv: got %0d exp %0d", inv, e_inv); else pass++;
        drive(1'b0, 0, 1'b1, 40, 1'b0);
        idle(1);
        chk++; if (pos !== 48'(e_pos1)) $display("FAIL hyst_pos: got %0d exp %0d", pos, e_pos1); else pass++;
        chk++; if (long_f !== e_l1) $display("FAIL hyst_hold: got %b exp %b", long_f, e_l1); else pass++;
        drive(1'b0, 0, 1'b1, 20, 1'b0);
        idle(1);
        chk++; if (pos !== 48'(e_pos2)) $display("FAIL rel_pos: got %0d exp %0d", pos, e_pos2); else pass++;
        chk++; if (long_f !== 0) $display("FAIL rel_flag: got %b exp 0", long_f); else pass++;
        chk++; if (short_f !== 0) $display("FAIL rel_short: got %b exp 0", short_f); else pass++;
    endtask

    task automatic test_short_limit();
        longint     e_pos;
        logic signed [63:0] e_inv;
        logic       e_s;
`ifdef INV_LIMIT_EN
        e_pos = -1000; e_inv = -64'sd17179869000; e_s = 1'b1;
`else
        e_pos = -1200; e_inv = -64'sd20615842800; e_s = 1'b0;
`endif
        do_clear();
        drive(1'b0, 0, 1'b1, 400, 1'b0);
        drive(1'b0, 0, 1'b1, 400, 1'b0);
        drive(1'b0, 0, 1'b1, 400, 1'b0);
        idle(1);
        chk++; if (pos !== 48'(e_pos)) $display("FAIL short_pos: got %0d exp %0d", pos, e_pos); else pass++;
        chk++; if (short_f !== e_s) $display("FAIL short_flag: got %b exp %b", short_f, e_s); else pass++;
        chk++; if (long_f !== 0) $display("FAIL short_long: got %b exp 0", long_f); else pass++;
        idle(1);
        chk++; if (inv !== e_inv) $display("FAIL short_inv: got %0d exp %0d", inv, e_inv); else pass++;
    endtask

    task automatic test_clear();
        do_clear();
        drive(1'b1, 400, 1'b0, 0, 1'b0);
        idle(2);
        drive(1'b1, 50, 1'b0, 0, 1'b1);
        chk++; if (pos !== 0) $display("FAIL clr_pos: got %0d exp 0", pos); else pass++;
        chk++; if (long_f !== 0 || short_f !== 0) $display("FAIL clr_flags: got %b%b exp 00", long_f, short_f); else pass++;
        chk++; if (inv !== 64'sd6871947600) $display("FAIL clr_inv_hold: got %0d exp 6871947600", inv); else pass++;
        idle(1);
        chk++; if (inv !== 0) $display("FAIL clr_inv: got %0d exp 0", inv); else pass++;
        chk++; if (inv_v !== 1) $display("FAIL clr_valid: got %b exp 1", inv_v); else pass++;
        idle(1);
        chk++; if (pos !== 0) $display("FAIL clr_discard: got %0d exp 0", pos); else pass++;
        chk++; if (inv_v !== 0) $display("FAIL clr_valid_pulse: got %b exp 0", inv_v); else pass++;
    endtask

    task automatic test_midstream_reset();
        do_clear();
        drive(1'b1, 100, 1'b0, 0, 1'b0);
        idle(1);
        drive(1'b1, 200, 1'b0, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk++; if (pos !== 0) $display("FAIL mrst_pos: got %0d exp 0", pos); else pass++;
        chk++; if (inv !== 0) $display("FAIL mrst_inv: got %0d exp 0", inv); else pass++;
        chk++; if (inv_v !== 0) $display("FAIL mrst_valid: got %b exp 0", inv_v); else pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        chk++; if (pos !== 0) $display("FAIL mrst_inflight: got %0d exp 0", pos); else pass++;
        drive(1'b1, 70, 1'b0, 0, 1'b0);
        idle(1);
        chk++; if (pos !== 70) $display("FAIL mrst_pos_after: got %0d exp 70", pos); else pass++;
        idle(1);
        chk++; if (inv !== 64'sd1202590830) $display("FAIL mrst_inv_after: got %0d exp 1202590830", inv); else pass++;
        chk++; if (inv_v !== 1) $display("FAIL mrst_valid_after: got %b exp 1", inv_v); else pass++;
    endtask

    task automatic test_back_to_back();
        do_clear();
        drive(1'b1, 10, 1'b0, 0, 1'b0);
        drive(1'b1, 20, 1'b0, 0, 1'b0);
        chk++; if (pos !== 10) $display("FAIL b2b_pos0: got %0d exp 10", pos); else pass++;
        drive(1'b1, 30, 1'b0, 0, 1'b0);
        chk++; if (pos !== 30) $display("FAIL b2b_pos1: got %0d exp 30", pos); else pass++;
        chk++; if (inv !== 64'sd171798690 || inv_v !== 1) $display("FAIL b2b_inv0: got %0d/%b exp 171798690/1", inv, inv_v); else pass++;
        drive(1'b0, 0, 1'b1, 0, 1'b0);  // zero-quantity fill
        chk++; if (pos !== 60) $display("FAIL b2b_pos2: got %0d exp 60", pos); else pass++;
        chk++; if (inv !== 64'sd515396070 || inv_v !== 1) $display("FAIL b2b_inv1: got %0d/%b exp 515396070/1", inv, inv_v); else pass++;
        idle(1);
        chk++; if (pos !== 60) $display("FAIL b2b_zero_pos: got %0d exp 60", pos); else pass++;
        chk++; if (inv !== 64'sd1030792140 || inv_v !== 1) $display("FAIL b2b_inv2: got %0d/%b exp 1030792140/1", inv, inv_v); else pass++;
        idle(1);
        chk++; if (inv_v !== 1) $display("FAIL b2b_zero_valid: got %b exp 1", inv_v); else pass++;
        idle(1);
        chk++; if (inv_v !== 0) $display("FAIL b2b_idle: got %b exp 0", inv_v); else pass++;
    endtask

    initial begin
        test_reset();
        test_single_bid();
        test_netting();
        test_long_limit();
        test_short_limit();
        test_clear();
        test_midstream_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
